aes128_decrypt_core: RTL and testbench
======================================

// Module: aes128_decrypt_core
// PURPOSE
//  Iterative AES-128 (FIPS-197) block decryptor: one 128-bit ciphertext + 128-bit key -> plaintext.
//  Performs forward key expansion, then 10 inverse rounds at one round per clock.
//  Sits behind the crypto datapath as the decryption engine; start/done level handshake.
// PARAMETERS
//  none (AES-128 fixed); localparam NR = 10 rounds, NK = 4 key words.
// PORTS
//  clk         in   1    rising-edge clock; the only clock
//  reset_n     in   1    synchronous, active-HIGH reset (asserted = 1); codebase port name retained
//  start       in   1    request; level, sampled in IDLE
//  key         in   128  cipher key; bits[127:120] = key byte 0 (FIPS order)
//  ciphertext  in   128  input block; bits[127:120] = state byte 0 (column-major)
//  plaintext   out  128  result, registered; valid while done = 1
//  done        out  1    registered; high in DONE state
// BEHAVIOUR
//  Reset (edge with reset_n = 1): state <= IDLE, done <= 0, plaintext <= 0, round counter <= 0.
//  Reset mid-operation aborts immediately; no partial result is exposed.
//  FSM: IDLE -> KEYEXP -> INIT -> ROUND -> DONE.
//  IDLE: done = 0; on start = 1, latch key into rk[0] and ciphertext into ct_reg; -> KEYEXP.
//  key/ciphertext are ignored after latching; start is ignored outside IDLE/DONE.
//  KEYEXP: 10 cycles, cycle i computes rk[i] = f(rk[i-1], RCON[i]) (RotWord, SubWord, XOR); -> INIT after rk[10].
//  INIT: 1 cycle, st <= ct_reg ^ rk[10]; r <= 9; -> ROUND.
//  ROUND: 10 cycles, r = 9..0: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk[r]).
//   InvMixColumns is skipped when r = 0; on r = 0 the result loads into plaintext, done <= 1, -> DONE.
//  Latency: start sampled at edge N -> plaintext/done valid after edge N+21.
//  DONE: done = 1, plaintext held. Leaves to IDLE only when start = 0.
//   If start stays high, no new operation runs; plaintext holds.
//   Next operation needs start low for >= 1 cycle, then high.
//  Leaving DONE: done <= 0 and plaintext holds its last value until overwritten.
//  GF(2^8) arithmetic uses polynomial 0x11B. InvMixColumns coefficients: 0e, 0b, 0d, 09.
//  Round-key storage: 11 x 128-bit register array.
// CONFIGURATION
//  AES_DEC_KEY_CACHE_EN defined:
//   - Holds a key_valid flag plus the last expanded key; reset clears key_valid.
//   - On start with key_valid = 1 and key == rk[0], KEYEXP is skipped (IDLE -> INIT).
//   - Latency is then 11 edges; a different key goes through KEYEXP (21 edges).
//  Undefined: no flag, KEYEXP always runs, fixed 21-edge latency.
//  Outputs are bit-identical in both builds.
// STRUCTURE
//  Package aes_pkg:
//   - SBOX and INV_SBOX 256x8 constant tables
//   - RCON[1..10]
//   - functions xtime, gmul, sub_word, rot_word
//   - state enum {IDLE, KEYEXP, INIT, ROUND, DONE}
//  Sub-module aes_inv_round: combinational; in: st, rk, last -> out next st.
//  Key expansion and FSM live in the top.
// TESTING
//  FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, done at edge N+21.
//  FIPS-197 App.B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
//  Key DF69A7E105D8963B1685FFCCEE3369FA, ct 029795d9d0d6129e96f5c12ffe23e5d0, start held high 60 cycles:
//   pt equals golden software AES-128 decrypt; done stays 1; no re-run.
//  Assert reset_n for 1 edge at round 5:
//   done = 0, plaintext = 0, FSM IDLE next cycle; a fresh start then yields correct pt.
//  Change key/ciphertext mid-operation: result matches the values latched at start.
//  With AES_DEC_KEY_CACHE_EN, back-to-back ops with the same key (C.1 then ct = C.1 re-encrypted):
//   second done at edge N+11; with a new key, edge N+21.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, GF(2^8) helpers and the decryptor FSM
// state type. Imported by aes_inv_round and aes128_decrypt_core.
package aes_pkg;

  localparam int NR = 10;  // cipher rounds
  localparam int NK = 4;   // 32-bit words per key

  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, DONE} state_e;

  // Forward S-box, used only by key expansion; entry 0 sits in the MSBs.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box, used by every decryption round.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // One step of forward key expansion: round key i from round key i-1.
  function automatic logic [127:0] key_step(input logic [127:0] prev, input logic [7:0] rcon);
    logic [31:0]  w;
    logic [127:0] nxt;
    nxt = '0;
    w   = sub_word(rot_word(prev[31:0])) ^ {rcon, 24'h0};
    for (int j = 0; j < NK; j++) begin
      w = w ^ prev[127-32*j -: 32];
      nxt[127-32*j -: 32] = w;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round.
// out = InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk); InvMixColumns bypassed when last_i.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] st_o
);

  logic [127:0] ark;
  logic [127:0] mixed;

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  // Byte (row, col) lives at index 4*col+row; row r is rotated right by r columns.
  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no path can infer a latch.
    ark   = '0;
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ark[127-8*(4*c+r) -: 8] = INV_SBOX[st_i[127-8*(4*((c-r+4)%4)+r) -: 8]]
                                  ^ rk_i[127-8*(4*c+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = inv_mix_column(ark[127-32*c -: 32]);
    end
  end

  assign st_o = last_i ? ark : mixed;

endmodule

// File: rtl/aes128_decrypt_core.sv
// aes128_decrypt_core: iterative AES-128 decryptor, one inverse round per clock.
// Forward key expansion (10 cycles), whitening (1 cycle), 10 inverse rounds.
// Optional build macro AES_DEC_KEY_CACHE_EN: skip key expansion when the key
// matches the last fully expanded one.
module aes128_decrypt_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,    // synchronous, active high
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] ciphertext,
  output logic [127:0] plaintext,
  output logic         done
);

  localparam logic [3:0] LAST_RK = 4'(NR);

  state_e       state_q, state_d;
  logic [3:0]   round_q;
  logic         done_q;
  logic [127:0] plaintext_q;
  logic [127:0] rk_q [NR+1];
  logic [127:0] kw_q;          // most recently produced round key during expansion
  logic [127:0] ct_q;
  logic [127:0] st_q;
  logic [127:0] rk_next;
  logic [127:0] round_out;
  logic         key_hit;

  assign rk_next = key_step(kw_q, RCON[round_q]);

  aes_inv_round u_inv_round (
    .st_i   (st_q),
    .rk_i   (rk_q[round_q]),
    .last_i (round_q == 4'd0),
    .st_o   (round_out)
  );

`ifdef AES_DEC_KEY_CACHE_EN
  logic key_valid_q;

  // Track whether rk_q holds a complete expansion of rk_q[0].
  always_ff @(posedge clk) begin
    if (reset_n)                                       key_valid_q <= 1'b0;
    else if (state_q == IDLE && start && !key_hit)     key_valid_q <= 1'b0;
    else if (state_q == KEYEXP && round_q == LAST_RK)  key_valid_q <= 1'b1;
  end

  assign key_hit = key_valid_q && (key == rk_q[0]);
`else
  assign key_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = key_hit ? INIT : KEYEXP;
      KEYEXP:  if (round_q == LAST_RK) state_d = INIT;
      INIT:    state_d = ROUND;
      ROUND:   if (round_q == 4'd0) state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Resettable control and outputs: round counter, done flag, result.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      round_q     <= '0;
      done_q      <= 1'b0;
      plaintext_q <= '0;
    end else begin
      unique case (state_q)
        IDLE:   if (start) round_q <= 4'd1;
        KEYEXP: if (round_q != LAST_RK) round_q <= round_q + 4'd1;
        INIT:   round_q <= LAST_RK - 4'd1;
        ROUND: begin
          if (round_q == 4'd0) begin
            plaintext_q <= round_out;
            done_q      <= 1'b1;
          end else begin
            round_q <= round_q - 4'd1;
          end
        end
        DONE:   if (!start) done_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Datapath storage: key schedule, latched ciphertext, round state.
  // NOTE: these are storage only, never observed before being written, so they carry no reset.
  always_ff @(posedge clk) begin
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ct_q <= ciphertext;
          if (!key_hit) begin
            rk_q[0] <= key;
            kw_q    <= key;
          end
        end
      end
      KEYEXP: begin
        rk_q[round_q] <= rk_next;
        kw_q          <= rk_next;
      end
      INIT:    st_q <= ct_q ^ rk_q[NR];
      ROUND:   st_q <= round_out;
      default: ;
    endcase
  end

  assign plaintext = plaintext_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes128_decrypt_core.sv
// tb_aes128_decrypt_core: randomized and known-answer bench for aes128_decrypt_core.
// The reference model builds its S-boxes from GF(2^8) inversion plus the affine map
// and decrypts on byte arrays.
module tb_aes128_decrypt_core;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic [127:0] plaintext;
  logic         done;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  bit           cache_valid = 1'b0;
  logic [127:0] cache_key   = '0;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE_BUILD = 1'b1;
`else
  localparam bit CACHE_BUILD = 1'b0;
`endif

  always #5 clk = ~clk;

  aes128_decrypt_core dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .key        (key),
    .ciphertext (ciphertext),
    .plaintext  (plaintext),
    .done       (done)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] x;
    logic [7:0] p;
    p = '0;
    x = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x[7:0];
      x = x << 1;
      if (x[8]) x = x ^ 9'h11b;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] aes_dec(input logic [127:0] k, input logic [127:0] ct);
    logic [7:0]   w [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tw [4];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tw[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        tw = '{sb[w[4*i-3]], sb[w[4*i-2]], sb[w[4*i-1]], sb[w[4*i-4]]};
        tw[0] = tw[0] ^ rc;
        rc = gf_mul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tw[j];
    end
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ w[160+i];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++)
          t[4*col+row] = isb[s[4*((col-row+4)%4)+row]] ^ w[16*rnd+4*col+row];
      for (int col = 0; col < 4; col++) begin
        a0 = t[4*col]; a1 = t[4*col+1]; a2 = t[4*col+2]; a3 = t[4*col+3];
        if (rnd > 0) begin
          s[4*col]   = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
          s[4*col+1] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
          s[4*col+2] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
          s[4*col+3] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end else begin
          s[4*col] = a0; s[4*col+1] = a1; s[4*col+2] = a2; s[4*col+3] = a3;
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One operation: pulse start, optionally disturb the inputs right after, measure
  // edges from the sampling edge to done, then drop back to IDLE.
  task automatic run_op(input string tag, input logic [127:0] k, input logic [127:0] c,
                        input logic [127:0] exp_pt, input bit disturb);
    int lat;
    int exp_lat;
    exp_lat = (CACHE_BUILD && cache_valid && k == cache_key) ? 11 : 21;
    @(negedge clk);
    key = k; ciphertext = c; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (disturb) begin
      key        = ~k;
      ciphertext = c ^ rand128();
    end
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) lat = i;
    end
    check({tag, " latency"}, 128'(lat), 128'(exp_lat));
    check({tag, " plaintext"}, plaintext, exp_pt);
    cache_valid = 1'b1;
    cache_key   = k;
    @(posedge clk); #1;
    check({tag, " done drop"}, {127'b0, done}, 128'b0);
    check({tag, " pt hold"}, plaintext, exp_pt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] k, c, exp;
    int lat, bad;
    build_tables();
    reset_n = 1'b1; start = 1'b0; key = '0; ciphertext = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset done", {127'b0, done}, 128'b0);
    check("reset plaintext", plaintext, 128'b0);
    reset_n = 1'b0;

    // Known answers.
    run_op("fips_c1", 128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
           128'h00112233445566778899aabbccddeeff, 1'b0);
    run_op("fips_b", 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
           128'h3243f6a8885a308d313198a2e0370734, 1'b0);
    // Same key back to back: the second run may use the cached schedule.
    run_op("c1_again", 128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
           128'h00112233445566778899aabbccddeeff, 1'b0);
    c = rand128();
    run_op("c1_samekey", 128'h000102030405060708090a0b0c0d0e0f, c,
           aes_dec(128'h000102030405060708090a0b0c0d0e0f, c), 1'b0);

    // Start held high: one run only, result and done held.
    k = 128'hdf69a7e105d8963b1685ffccee3369fa;
    c = 128'h029795d9d0d6129e96f5c12ffe23e5d0;
    exp = aes_dec(k, c);
    @(negedge clk);
    key = k; ciphertext = c; start = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) lat = i;
    end
    check("hold latency", 128'(lat), 128'd21);
    check("hold plaintext", plaintext, exp);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b1 || plaintext !== exp) bad++;
    end
    check("hold stable cycles bad", 128'(bad), 128'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("hold release done", {127'b0, done}, 128'b0);
    cache_valid = 1'b1; cache_key = k;

    // Reset at round 5 aborts the operation.
    k = rand128(); c = rand128();
    @(negedge clk);
    key = k; ciphertext = c; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("abort done", {127'b0, done}, 128'b0);
    check("abort plaintext", plaintext, 128'b0);
    @(negedge clk);
    reset_n = 1'b0;
    cache_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || plaintext !== 128'b0) bad++;
    end
    check("abort idle cycles bad", 128'(bad), 128'd0);
    run_op("after_abort", k, c, aes_dec(k, c), 1'b0);

    // Inputs changed right after latching must not matter.
    k = rand128(); c = rand128();
    run_op("disturb", k, c, aes_dec(k, c), 1'b1);

    // Random operations, every third one reusing the previous key.
    for (int i = 0; i < 8; i++) begin
      k = (i % 3 == 2) ? cache_key : rand128();
      c = rand128();
      run_op($sformatf("rand%0d", i), k, c, aes_dec(k, c), (i % 4 == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
